// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reconfiguration controller: FSM states, divider
// select types and the per-state registered status word.
package pll_ctrl_pkg;

  localparam int SEL_W = 6;

  typedef logic [SEL_W-1:0] pll_sel_t;

  typedef struct packed {
    pll_sel_t idsel;
    pll_sel_t fbdsel;
    pll_sel_t odsel;
  } pll_cfg_t;

  typedef enum logic [2:0] {
    ST_RST_HOLD   = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE_CHK = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } pll_state_e;

  typedef struct packed {
    logic pll_reset;
    logic clk_ok;
    logic busy;
    logic err;
    logic cfg_ready;
  } pll_status_t;

  // Status outputs are a pure function of the state being entered, so the
  // FSM registers them together with the state.
  function automatic pll_status_t status_for(input pll_state_e st);
    pll_status_t s;
    s.pll_reset = (st == ST_RST_HOLD) || (st == ST_FAIL);
    s.clk_ok    = (st == ST_RUN);
    s.busy      = (st == ST_RST_HOLD) || (st == ST_WAIT_LOCK) || (st == ST_STABLE_CHK);
    s.err       = (st == ST_FAIL);
    s.cfg_ready = (st == ST_RUN) || (st == ST_FAIL);
    return s;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the clk domain.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL divider reconfiguration: reset hold, lock wait with timeout/retry, lock
// qualification and run/fail reporting. Optional macro PLL_LOCK_MONITOR_EN.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int       RESET_HOLD_CYCLES   = 16,
  parameter int       LOCK_STABLE_CYCLES  = 1024,
  parameter int       LOCK_TIMEOUT_CYCLES = 65535,
  parameter int       MAX_RETRIES         = 3,
  parameter pll_sel_t DEF_IDSEL           = 6'd6,
  parameter pll_sel_t DEF_FBDSEL          = 6'd12,
  parameter pll_sel_t DEF_ODSEL           = 6'd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_idsel,
  input  logic [SEL_W-1:0] cfg_fbdsel,
  input  logic [SEL_W-1:0] cfg_odsel,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  output logic             clk_ok,
  output logic             busy,
  output logic             err
);

  localparam int HOLD_W  = (RESET_HOLD_CYCLES   > 1) ? $clog2(RESET_HOLD_CYCLES)   : 1;
  localparam int STAB_W  = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
  localparam int TOUT_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  // The retry counter must be able to hold MAX_RETRIES itself.
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TOUT_W-1:0]  TOUT_LAST = TOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [STAB_W-1:0] stab_inc(input logic [STAB_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [TOUT_W-1:0] tout_inc(input logic [TOUT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (pll_lock),
    .sync_o  (lock_s)
  );

  pll_state_e         state_q;
  pll_status_t        stat_q;
  pll_cfg_t           sel_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [STAB_W-1:0]  stab_q;
  logic [TOUT_W-1:0]  tout_q;
  logic [RETRY_W-1:0] retry_q;
  logic               accept_d;

  // cfg_ready is registered and only high in RUN/FAIL, so requests arriving
  // while busy are simply dropped.
  assign accept_d = cfg_valid && stat_q.cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST_HOLD;
      stat_q  <= status_for(ST_RST_HOLD);
      sel_q   <= {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL};
      hold_q  <= '0;
      stab_q  <= '0;
      tout_q  <= '0;
      retry_q <= '0;
    end else if (accept_d) begin
      state_q <= ST_RST_HOLD;
      stat_q  <= status_for(ST_RST_HOLD);
      sel_q   <= {cfg_idsel, cfg_fbdsel, cfg_odsel};
      hold_q  <= '0;
      retry_q <= '0;
    end else begin
      unique case (state_q)
        ST_RST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_WAIT_LOCK;
            stat_q  <= status_for(ST_WAIT_LOCK);
            tout_q  <= '0;
          end else begin
            hold_q <= hold_inc(hold_q);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= ST_STABLE_CHK;
            stat_q  <= status_for(ST_STABLE_CHK);
            stab_q  <= '0;
          end else if (tout_q == TOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_inc(retry_q);
              hold_q  <= '0;
              state_q <= ST_RST_HOLD;
              stat_q  <= status_for(ST_RST_HOLD);
            end else begin
              state_q <= ST_FAIL;
              stat_q  <= status_for(ST_FAIL);
            end
          end else begin
            tout_q <= tout_inc(tout_q);
          end
        end
        ST_STABLE_CHK: begin
          // A lock drop resumes waiting without restarting the timeout budget.
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            stat_q  <= status_for(ST_WAIT_LOCK);
          end else if (stab_q == STAB_LAST) begin
            state_q <= ST_RUN;
            stat_q  <= status_for(ST_RUN);
            retry_q <= '0;
          end else begin
            stab_q <= stab_inc(stab_q);
          end
        end
        ST_RUN: begin
`ifdef PLL_LOCK_MONITOR_EN
          if (!lock_s) begin
            state_q <= ST_RST_HOLD;
            stat_q  <= status_for(ST_RST_HOLD);
            hold_q  <= '0;
            retry_q <= '0;
          end
`endif
        end
        ST_FAIL: begin
          state_q <= ST_FAIL;
        end
        default: begin
          state_q <= ST_RST_HOLD;
          stat_q  <= status_for(ST_RST_HOLD);
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign pll_reset  = stat_q.pll_reset;
  assign clk_ok     = stat_q.clk_ok;
  assign busy       = stat_q.busy;
  assign err        = stat_q.err;
  assign cfg_ready  = stat_q.cfg_ready;
  assign pll_idsel  = sel_q.idsel;
  assign pll_fbdsel = sel_q.fbdsel;
  assign pll_odsel  = sel_q.odsel;

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter RESET_HOLD_CYCLES, default 16, cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before clk_ok.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65535, maximum cycles waiting for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, re-attempts after the first timeout before FAIL.
REQ-005 SHALL have parameters DEF_IDSEL/DEF_FBDSEL/DEF_ODSEL, each 6 bits, defaults 6, 12, 8, the divider selects applied after reset.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 cfg_valid  in  1  request to apply a new divider set.
REQ-009 cfg_ready  out  1  high only in RUN or FAIL; request accepted on cfg_valid&&cfg_ready.
REQ-010 cfg_idsel, cfg_fbdsel, cfg_odsel  in  6 each  requested selects, passed through unencoded.
REQ-011 pll_lock  in  1  raw PLL LOCK, asynchronous to clk.
REQ-012 pll_reset  out  1  drives PLL RESET.
REQ-013 pll_idsel, pll_fbdsel, pll_odsel  out  6 each  registered selects to PLL IDSEL/FBDSEL/ODSEL.
REQ-014 clk_ok  out  1  PLL output clock usable; high only in RUN.
REQ-015 busy  out  1  high in RST_HOLD, WAIT_LOCK, STABLE_CHK.
REQ-016 err  out  1  high only in FAIL.

Function
REQ-017 pll_lock SHALL pass a 2-flop synchronizer; all lock decisions use the synchronized value (lock_s).
REQ-018 States SHALL be RST_HOLD, WAIT_LOCK, STABLE_CHK, RUN, FAIL.
REQ-019 RST_HOLD: pll_reset=1 for exactly RESET_HOLD_CYCLES cycles, then WAIT_LOCK with timeout counter cleared.
REQ-020 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE_CHK with stable counter cleared; timeout counter reaching LOCK_TIMEOUT_CYCLES -> retry.
REQ-021 Retry: retry counter < MAX_RETRIES -> increment, RST_HOLD with same selects; otherwise FAIL.
REQ-022 STABLE_CHK: lock_s=0 -> WAIT_LOCK (timeout counter not cleared); LOCK_STABLE_CYCLES consecutive lock_s=1 -> RUN, retry counter cleared.
REQ-023 Accepted request SHALL latch cfg_* into pll_* on the accepting edge, clear retry counter, enter RST_HOLD; pll_* SHALL NOT change otherwise.
REQ-024 cfg_valid outside RUN/FAIL SHALL be ignored (not queued).
REQ-025 FAIL SHALL hold pll_reset=1 until rst or a new accepted request.
REQ-026 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.
REQ-027 Outputs SHALL be registered; clk_ok rises the cycle after the final stable-count cycle.

Reset
REQ-028 On rst: state=RST_HOLD, pll_reset=1, pll_*=DEF_*, clk_ok=0, busy=1, err=0, cfg_ready=0, all counters and synchronizer flops 0.
REQ-029 rst mid-sequence SHALL abandon the attempt and restart from REQ-028, discarding any latched request.

Configuration
REQ-030 Macro PLL_LOCK_MONITOR_EN: when defined, lock_s=0 in RUN SHALL drop clk_ok next cycle and enter RST_HOLD with current selects and retry counter cleared.
REQ-031 Without PLL_LOCK_MONITOR_EN, RUN SHALL ignore lock_s; clk_ok stays 1 until a new request or rst.

Structure
REQ-032 Shared package pll_ctrl_pkg SHALL hold the state enum and the 6-bit select typedef.
REQ-033 Sub-module pll_lock_sync (2-flop synchronizer) SHALL be instantiated once.

Verification (bench params RESET_HOLD=4, LOCK_STABLE=8, TIMEOUT=32, MAX_RETRIES=2)
REQ-034 Reset, pll_lock rises 10 cycles after reset release -> pll_reset high 4 cycles, clk_ok=1 at lock+2+8+1 cycles, pll_*=6/12/8.
REQ-035 In RUN, request 10/20/4 -> pll_* = 10/20/4 next cycle, pll_reset pulse of 4 cycles, clk_ok low until relock stable.
REQ-036 pll_lock held 0 -> exactly 3 pll_reset pulses, then err=1, cfg_ready=1, pll_reset stays 1.
REQ-037 Lock glitch low 1 cycle at stable count 5 -> STABLE_CHK restarts, clk_ok delayed by the full 8 cycles.
REQ-038 With PLL_LOCK_MONITOR_EN, drop lock in RUN -> clk_ok=0 and pll_reset pulse; without macro -> clk_ok stays 1.
REQ-039 Assert rst during WAIT_LOCK after a 10/20/4 request -> pll_* return to 6/12/8, sequence restarts.
